dmem_arbiter: RTL

Shares the single data-memory port between the processor core's load/store path and a host loader/debug port that moves bursts of 64-bit words. Sits between the core's memory-control signals (address from the ALU result, write data from register output B, read/write strobes) and the DataMemory instance. The core gets the memory with zero added latency whenever no host burst is active. A host burst preempts the core only when the core is idle or after a bounded wait, and `core_stall` is raised while the host owns the port.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arbiter_if.sv | 28 ++
 rtl/burst_counter.sv | 47 ++++
 rtl/dmem_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Addresses are 64-bit byte addresses. A word is 8 bytes.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      HOST_BURST = 2'd1,
      HOST_GAP   = 2'd2
   } arb_state_e;

   localparam int unsigned WORD_BYTES      = 8;
   localparam logic [63:0] ADDR_ALIGN_MASK = ~(64'(WORD_BYTES) - 64'd1);

   function automatic logic [63:0] align_addr(input logic [63:0] a);
      return a & ADDR_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Host loader/debug burst port. The master side is the host.
// The slave side is the arbiter.
interface dmem_arbiter_if #(
   parameter int unsigned BURST_W = 4
) ();

   logic               host_req;
   logic               host_we;
   logic [63:0]        host_addr;
   logic [BURST_W-1:0] host_len;
   logic               host_ack;
   logic [63:0]        host_wdata;
   logic               host_wready;
   logic [63:0]        host_rdata;
   logic               host_rvalid;
   logic               host_done;

   modport master (
      output host_req, host_we, host_addr, host_len, host_wdata,
      input  host_ack, host_wready, host_rdata, host_rvalid, host_done
   );

   modport slave (
      input  host_req, host_we, host_addr, host_len, host_wdata,
      output host_ack, host_wready, host_rdata, host_rvalid, host_done
   );

endinterface

// File: rtl/burst_counter.sv
// Beat counter and word address for a host burst.
// It loads on ack and then steps by one word per beat.
module burst_counter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned BURST_W = 4
) (
   input  logic               CLK,
   input  logic               resetl,
   input  logic               load_i,
   input  logic [BURST_W-1:0] len_i,
   input  logic [63:0]        addr_i,
   input  logic               step_i,
   output logic               last_o,
   output logic [63:0]        addr_o
);

   logic [BURST_W-1:0] cnt_q, cnt_d;
   logic [63:0]        addr_q, addr_d;

   always_comb begin
      cnt_d  = cnt_q;
      addr_d = addr_q;
      if (load_i) begin
         cnt_d  = len_i;
         addr_d = align_addr(addr_i);
      end else if (step_i) begin
         // The address wraps modulo 2^64 through plain overflow.
         cnt_d  = cnt_q - 1'b1;
         addr_d = addr_q + 64'(WORD_BYTES);
      end
   end

   always_ff @(negedge CLK or negedge resetl) begin
      if (!resetl) begin
         cnt_q  <= '0;
         addr_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         addr_q <= addr_d;
      end
   end

   assign last_o = (cnt_q == '0);
   assign addr_o = addr_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the DataMemory port between the core load/store path and host bursts.
// The core passes through combinationally. A host burst preempts the core when the core is idle or after MAX_WAIT cycles.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 8,
   parameter int unsigned BURST_W  = 4
) (
   input  logic        CLK,
   input  logic        resetl,
   input  logic        core_req,
   input  logic        core_we,
   input  logic [63:0] core_addr,
   input  logic [63:0] core_wdata,
   output logic [63:0] core_rdata,
   output logic        core_stall,
   dmem_arbiter_if.slave host,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [63:0] mem_rdata
);

   localparam int unsigned WAIT_W = $clog2(MAX_WAIT) + 1;

   arb_state_e        state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              we_q, we_d;
   logic              launch;
   logic              bc_last;
   logic [63:0]       bc_addr;

   assign launch = (state_q == IDLE) && host.host_req
                   && (!core_req || (wait_q == WAIT_W'(MAX_WAIT - 1)));

   burst_counter #(.BURST_W(BURST_W)) u_burst_counter (
      .CLK    (CLK),
      .resetl (resetl),
      .load_i (launch),
      .len_i  (host.host_len),
      .addr_i (host.host_addr),
      .step_i (state_q == HOST_BURST),
      .last_o (bc_last),
      .addr_o (bc_addr)
   );

   always_comb begin
      state_d = state_q;
      wait_d  = '0;
      we_d    = we_q;
      unique case (state_q)
         IDLE: begin
            if (launch) begin
               state_d = HOST_BURST;
               we_d    = host.host_we;
            end else if (host.host_req && core_req) begin
               wait_d = wait_q + 1'b1;
            end
         end
         HOST_BURST: if (bc_last) state_d = HOST_GAP;
         HOST_GAP:   state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_ff @(negedge CLK or negedge resetl) begin
      if (!resetl) begin
         state_q <= IDLE;
         wait_q  <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         we_q    <= we_d;
      end
   end

   always_comb begin
      mem_addr         = core_addr;
      mem_wdata        = core_wdata;
      mem_read         = core_req & ~core_we;
      mem_write        = core_req & core_we;
      core_rdata       = mem_rdata;
      core_stall       = 1'b0;
      host.host_ack    = launch;
      host.host_wready = 1'b0;
      host.host_rvalid = 1'b0;
      host.host_rdata  = '0;
      host.host_done   = 1'b0;
      if (state_q == HOST_BURST) begin
         mem_addr         = bc_addr;
         mem_wdata        = host.host_wdata;
         mem_read         = ~we_q;
         mem_write        = we_q;
         core_rdata       = '0;
         core_stall       = core_req;
         host.host_wready = we_q;
         host.host_rvalid = ~we_q;
         host.host_rdata  = we_q ? '0 : mem_rdata;
         host.host_done   = bc_last;
      end
      // Reset gates the strobes asynchronously so no write slips out while resetl is low.
      if (!resetl) begin
         mem_read         = 1'b0;
         mem_write        = 1'b0;
         core_stall       = 1'b0;
         host.host_ack    = 1'b0;
         host.host_wready = 1'b0;
         host.host_rvalid = 1'b0;
         host.host_done   = 1'b0;
      end
   end

endmodule
